// File: rtl/alu_issue_ctrl_if.sv
// Request/response handshake bundle between the register-read stage and
// the ALU issue controller. The upstream stage is the master; the
// controller is the slave.
interface alu_issue_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_instr;
    logic [31:0] req_rs;
    logic [31:0] req_rt;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_z;
    logic        rsp_zero;
    logic        rsp_err;

    modport master (
        output req_valid, req_instr, req_rs, req_rt, rsp_ready,
        input  req_ready, rsp_valid, rsp_z, rsp_zero, rsp_err
    );

    modport slave (
        input  req_valid, req_instr, req_rs, req_rt, rsp_ready,
        output req_ready, rsp_valid, rsp_z, rsp_zero, rsp_err
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts an instruction plus two register values,
// decodes the ALU op and B operand, holds the ALU inputs for SETTLE_CYCLES,
// then captures the ALU result and returns it over a valid/ready response.
module alu_issue_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned CNT_W         = 4
) (
    input  logic               clk,
    input  logic               reset,
    alu_issue_ctrl_if.slave    bus,
    output logic [31:0]        alu_a,
    output logic [31:0]        alu_b,
    output logic [2:0]         alu_op,
    input  logic [31:0]        alu_z
);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        RESP   = 2'd3
    } state_e;

    typedef struct packed {
        logic        legal;
        logic [2:0]  op;
        logic [31:0] b;
    } dec_t;

    // Instruction decode: ALU op and B operand; A is always rs.
    function automatic dec_t decode(input logic [31:0] instr, input logic [31:0] rt);
        dec_t        d;
        logic [31:0] imm_sx;
        logic [31:0] imm_zx;
        imm_sx  = {{16{instr[15]}}, instr[15:0]};
        imm_zx  = {16'h0000, instr[15:0]};
        d.legal = 1'b1;
        d.op    = OP_ADD;
        d.b     = rt;
        case (instr[31:26])
            6'h00: begin
                case (instr[5:0])
                    6'h20:   d.op = OP_ADD;
                    6'h22:   d.op = OP_SUB;
                    6'h24:   d.op = OP_AND;
                    6'h25:   d.op = OP_OR;
                    6'h2A:   d.op = OP_SLT;
                    default: d.legal = 1'b0;
                endcase
            end
            6'h08:   d.b = imm_sx;
            6'h0A: begin
                d.op = OP_SLT;
                d.b  = imm_sx;
            end
            6'h0C: begin
                d.op = OP_AND;
                d.b  = imm_zx;
            end
            6'h0D: begin
                d.op = OP_OR;
                d.b  = imm_zx;
            end
            6'h23:   d.b = imm_sx;
            6'h2B:   d.b = imm_sx;
            6'h04:   d.op = OP_SUB;
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

    state_e             state_q, state_d;
    logic               req_ready_q, req_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        instr_q, instr_d;
    logic [31:0]        rs_q, rs_d;
    logic [31:0]        rt_q, rt_d;
    logic [31:0]        alu_a_q, alu_a_d;
    logic [31:0]        alu_b_q, alu_b_d;
    logic [2:0]         alu_op_q, alu_op_d;
    logic [31:0]        rsp_z_q, rsp_z_d;
    logic               rsp_zero_q, rsp_zero_d;
    logic               rsp_err_q, rsp_err_d;
    dec_t               dec_s;
    logic               accept_s;
    logic               unused_instr_s;

    assign dec_s    = decode(instr_q, rt_q);
    assign accept_s = bus.req_valid & req_ready_q;
    // Register-specifier fields are not needed; operand values arrive separately.
    assign unused_instr_s = ^instr_q[25:16];

    // State and handshake-flag register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // Datapath register: latched request, ALU drive, captured response.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= {CNT_W{1'b0}};
            instr_q    <= 32'h0000_0000;
            rs_q       <= 32'h0000_0000;
            rt_q       <= 32'h0000_0000;
            alu_a_q    <= 32'h0000_0000;
            alu_b_q    <= 32'h0000_0000;
            alu_op_q   <= 3'b000;
            rsp_z_q    <= 32'h0000_0000;
            rsp_zero_q <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            instr_q    <= instr_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            rsp_z_q    <= rsp_z_d;
            rsp_zero_q <= rsp_zero_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_s) state_d = DECODE;
                else          state_d = IDLE;
            end
            DECODE: begin
                if (dec_s.legal) state_d = EXEC;
                else             state_d = RESP;
            end
            EXEC: begin
                if (cnt_q == CNT_W'(1)) state_d = RESP;
                else                    state_d = EXEC;
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
                else               state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values; every register holds unless its state updates it.
    always_comb begin
        cnt_d      = cnt_q;
        instr_d    = instr_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        rsp_z_d    = rsp_z_q;
        rsp_zero_d = rsp_zero_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    instr_d = bus.req_instr;
                    rs_d    = bus.req_rs;
                    rt_d    = bus.req_rt;
                end else begin
                    instr_d = instr_q;
                end
            end
            DECODE: begin
                if (dec_s.legal) begin
                    alu_a_d  = rs_q;
                    alu_b_d  = dec_s.b;
                    alu_op_d = dec_s.op;
                    cnt_d    = CNT_W'(SETTLE_CYCLES);
                end else begin
                    // Undecodable: report an error with a zero result; ALU inputs untouched.
                    rsp_err_d  = 1'b1;
                    rsp_z_d    = 32'h0000_0000;
                    rsp_zero_d = 1'b1;
                end
            end
            EXEC: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    rsp_z_d    = alu_z;
                    rsp_zero_d = (alu_z == 32'h0000_0000);
                    rsp_err_d  = 1'b0;
                end else begin
                    rsp_err_d  = rsp_err_q;
                end
            end
            RESP: begin
                rsp_z_d = rsp_z_q;
            end
            default: begin
                cnt_d = {CNT_W{1'b0}};
            end
        endcase
        req_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_z     = rsp_z_q;
    assign bus.rsp_zero  = rsp_zero_q;
    assign bus.rsp_err   = rsp_err_q;
    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;
    assign alu_op        = alu_op_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: two instances (settle 1 and settle 4), a
// transaction-level timeline model checked every cycle, and directed
// transactions with hand-computed literal expectations.
module tb_alu_issue_ctrl;

    logic clk;
    logic reset;
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   last_hs     = 0;

    logic        req_valid_s [2];
    logic [31:0] req_instr_s [2];
    logic [31:0] req_rs_s    [2];
    logic [31:0] req_rt_s    [2];
    logic        rsp_ready_s [2];
    logic        req_ready_w [2];
    logic        rsp_valid_w [2];
    logic [31:0] rsp_z_w     [2];
    logic        rsp_zero_w  [2];
    logic        rsp_err_w   [2];
    logic [31:0] alu_a_w     [2];
    logic [31:0] alu_b_w     [2];
    logic [2:0]  alu_op_w    [2];
    logic [31:0] alu_z_s     [2];

    // model state per instance
    bit          m_busy  [2];
    int          m_acc   [2];
    int          m_lat   [2];
    logic        m_legal [2];
    logic [31:0] m_pa    [2];
    logic [31:0] m_pb    [2];
    logic [2:0]  m_pop   [2];
    logic [31:0] m_pz    [2];
    logic [31:0] e_a     [2];
    logic [31:0] e_b     [2];
    logic [2:0]  e_op    [2];
    logic [31:0] e_z     [2];
    logic        e_zero  [2];
    logic        e_err   [2];

    alu_issue_ctrl_if if0 ();
    alu_issue_ctrl_if if1 ();

    assign if0.req_valid = req_valid_s[0];
    assign if0.req_instr = req_instr_s[0];
    assign if0.req_rs    = req_rs_s[0];
    assign if0.req_rt    = req_rt_s[0];
    assign if0.rsp_ready = rsp_ready_s[0];
    assign req_ready_w[0] = if0.req_ready;
    assign rsp_valid_w[0] = if0.rsp_valid;
    assign rsp_z_w[0]     = if0.rsp_z;
    assign rsp_zero_w[0]  = if0.rsp_zero;
    assign rsp_err_w[0]   = if0.rsp_err;
    assign if1.req_valid = req_valid_s[1];
    assign if1.req_instr = req_instr_s[1];
    assign if1.req_rs    = req_rs_s[1];
    assign if1.req_rt    = req_rt_s[1];
    assign if1.rsp_ready = rsp_ready_s[1];
    assign req_ready_w[1] = if1.req_ready;
    assign rsp_valid_w[1] = if1.rsp_valid;
    assign rsp_z_w[1]     = if1.rsp_z;
    assign rsp_zero_w[1]  = if1.rsp_zero;
    assign rsp_err_w[1]   = if1.rsp_err;

    alu_issue_ctrl #(.SETTLE_CYCLES(1), .CNT_W(4)) u0 (
        .clk(clk), .reset(reset), .bus(if0.slave),
        .alu_a(alu_a_w[0]), .alu_b(alu_b_w[0]), .alu_op(alu_op_w[0]), .alu_z(alu_z_s[0])
    );
    alu_issue_ctrl #(.SETTLE_CYCLES(4), .CNT_W(4)) u1 (
        .clk(clk), .reset(reset), .bus(if1.slave),
        .alu_a(alu_a_w[1]), .alu_b(alu_b_w[1]), .alu_op(alu_op_w[1]), .alu_z(alu_z_s[1])
    );

    // Reference ALU: the op encodings as defined for the interface.
    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    assign alu_z_s[0] = alu_fn(alu_a_w[0], alu_b_w[0], alu_op_w[0]);
    assign alu_z_s[1] = alu_fn(alu_a_w[1], alu_b_w[1], alu_op_w[1]);

    function automatic int settle_of(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    // Decode table as a plain lookup.
    function automatic void m_decode(input logic [31:0] instr, input logic [31:0] rt,
                                     output logic legal, output logic [2:0] op, output logic [31:0] b);
        logic [31:0] sx;
        logic [31:0] zx;
        sx    = {{16{instr[15]}}, instr[15:0]};
        zx    = {16'h0000, instr[15:0]};
        legal = 1'b1;
        op    = 3'b010;
        b     = rt;
        case (instr[31:26])
            6'h00: case (instr[5:0])
                       6'h20: op = 3'b010;
                       6'h22: op = 3'b110;
                       6'h24: op = 3'b000;
                       6'h25: op = 3'b001;
                       6'h2A: op = 3'b111;
                       default: legal = 1'b0;
                   endcase
            6'h08: b = sx;
            6'h0A: begin op = 3'b111; b = sx; end
            6'h0C: begin op = 3'b000; b = zx; end
            6'h0D: begin op = 3'b001; b = zx; end
            6'h23, 6'h2B: b = sx;
            6'h04: op = 3'b110;
            default: legal = 1'b0;
        endcase
    endfunction

    task automatic chk(input int i, input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL u%0d %s: got %h expected %h", i, nm, act, exp);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Timeline model: per edge, decide accept/handshake and when outputs change.
    initial begin
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 1'b0; m_acc[i] = 0; m_lat[i] = 0; m_legal[i] = 1'b0;
            m_pa[i] = 32'd0; m_pb[i] = 32'd0; m_pop[i] = 3'd0; m_pz[i] = 32'd0;
            e_a[i] = 32'd0; e_b[i] = 32'd0; e_op[i] = 3'd0;
            e_z[i] = 32'd0; e_zero[i] = 1'b0; e_err[i] = 1'b0;
        end
        forever begin
            int c;
            int cn;
            @(posedge clk);
            c   = cyc;
            cn  = cyc + 1;
            cyc = cn;
            for (int i = 0; i < 2; i++) begin
                if (reset) begin
                    m_busy[i] = 1'b0;
                    e_a[i] = 32'd0; e_b[i] = 32'd0; e_op[i] = 3'd0;
                    e_z[i] = 32'd0; e_zero[i] = 1'b0; e_err[i] = 1'b0;
                end else if (m_busy[i]) begin
                    if (c >= m_acc[i] + m_lat[i] && rsp_ready_s[i]) begin
                        m_busy[i] = 1'b0;
                    end else begin
                        if (m_legal[i] && cn == m_acc[i] + 1) begin
                            e_a[i] = m_pa[i]; e_b[i] = m_pb[i]; e_op[i] = m_pop[i];
                        end
                        if (cn == m_acc[i] + m_lat[i]) begin
                            e_z[i]    = m_pz[i];
                            e_zero[i] = (m_pz[i] == 32'd0);
                            e_err[i]  = !m_legal[i];
                        end
                    end
                end else if (req_valid_s[i]) begin
                    logic        lg;
                    logic [2:0]  op;
                    logic [31:0] b;
                    m_decode(req_instr_s[i], req_rt_s[i], lg, op, b);
                    m_busy[i]  = 1'b1;
                    m_acc[i]   = cn;
                    m_legal[i] = lg;
                    m_pa[i]    = req_rs_s[i];
                    m_pb[i]    = b;
                    m_pop[i]   = op;
                    m_pz[i]    = lg ? alu_fn(req_rs_s[i], b, op) : 32'd0;
                    // edges from accept to response rise: decode + settle, or decode only
                    m_lat[i]   = lg ? settle_of(i) + 1 : 1;
                end
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                for (int i = 0; i < 2; i++) begin
                    logic ev;
                    ev = m_busy[i] && (cyc >= m_acc[i] + m_lat[i]);
                    chk(i, "rsp_valid", 32'(rsp_valid_w[i]), 32'(ev));
                    chk(i, "req_ready", 32'(req_ready_w[i]), 32'(!m_busy[i]));
                    chk(i, "rsp_z",     rsp_z_w[i], e_z[i]);
                    chk(i, "rsp_zero",  32'(rsp_zero_w[i]), 32'(e_zero[i]));
                    chk(i, "rsp_err",   32'(rsp_err_w[i]), 32'(e_err[i]));
                    chk(i, "alu_a",     alu_a_w[i], e_a[i]);
                    chk(i, "alu_b",     alu_b_w[i], e_b[i]);
                    chk(i, "alu_op",    32'(alu_op_w[i]), 32'(e_op[i]));
                end
            end
        end
    end

    // One request/response with literal expectations; latency counts the accept edge as edge 1.
    task automatic run_txn(input int i, input string nm, input logic [31:0] instr,
                           input logic [31:0] rs, input logic [31:0] rt, input int hold,
                           input bit b2b, input int exp_edges, input logic [31:0] ez,
                           input logic ezero, input logic eerr, input logic [31:0] ea,
                           input logic [31:0] eb, input logic [2:0] eop);
        int acc;
        bit got;
        req_instr_s[i] = instr;
        req_rs_s[i]    = rs;
        req_rt_s[i]    = rt;
        req_valid_s[i] = 1'b1;
        @(posedge clk); #1;
        acc = cyc;
        req_valid_s[i] = 1'b0;
        if (b2b) chk(i, {nm, "/accept_cycle"}, 32'(acc), 32'(last_hs + 1));
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (rsp_valid_w[i]) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk(i, {nm, "/latency_edges"}, got ? 32'(cyc - acc + 1) : 32'hFFFF_FFFF, 32'(exp_edges));
        if (got) begin
            repeat (hold) begin
                @(posedge clk); #1;
            end
            if (hold > 0) begin
                chk(i, {nm, "/held_valid"}, 32'(rsp_valid_w[i]), 32'd1);
                chk(i, {nm, "/held_req_ready"}, 32'(req_ready_w[i]), 32'd0);
            end
            chk(i, {nm, "/rsp_z"},    rsp_z_w[i], ez);
            chk(i, {nm, "/rsp_zero"}, 32'(rsp_zero_w[i]), 32'(ezero));
            chk(i, {nm, "/rsp_err"},  32'(rsp_err_w[i]), 32'(eerr));
            chk(i, {nm, "/alu_a"},    alu_a_w[i], ea);
            chk(i, {nm, "/alu_b"},    alu_b_w[i], eb);
            chk(i, {nm, "/alu_op"},   32'(alu_op_w[i]), 32'(eop));
            rsp_ready_s[i] = 1'b1;
            @(posedge clk); #1;
            rsp_ready_s[i] = 1'b0;
            last_hs = cyc;
            chk(i, {nm, "/released"}, 32'(rsp_valid_w[i]), 32'd0);
            chk(i, {nm, "/idle_ready"}, 32'(req_ready_w[i]), 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        for (int i = 0; i < 2; i++) begin
            req_valid_s[i] = 1'b0;
            req_instr_s[i] = 32'd0;
            req_rs_s[i]    = 32'd0;
            req_rt_s[i]    = 32'd0;
            rsp_ready_s[i] = 1'b0;
        end
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk(0, "reset/req_ready", 32'(req_ready_w[0]), 32'd1);
        chk(0, "reset/rsp_valid", 32'(rsp_valid_w[0]), 32'd0);
        chk(0, "reset/alu_a",     alu_a_w[0], 32'd0);
        chk(0, "reset/rsp_z",     rsp_z_w[0], 32'd0);

        //         inst name      instr         rs            rt           hold b2b edges z            zero  err   a             b             op
        run_txn(0, "add",   32'h00A7_3820, 32'd5,        32'd7,        0, 1'b0, 3, 32'd12,       1'b0, 1'b0, 32'd5,        32'd7,        3'b010);
        run_txn(0, "beq",   32'h10A7_0003, 32'h1234,     32'h1234,     0, 1'b1, 3, 32'd0,        1'b1, 1'b0, 32'h1234,     32'h1234,     3'b110);
        run_txn(0, "addi",  32'h2000_FFFF, 32'h10,       32'd0,        0, 1'b1, 3, 32'h0000_000F, 1'b0, 1'b0, 32'h10,      32'hFFFF_FFFF, 3'b010);
        run_txn(0, "andi",  32'h3000_8000, 32'hFFFF_FFFF, 32'd0,       0, 1'b1, 3, 32'h0000_8000, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_8000, 3'b000);
        run_txn(0, "illeg_funct", 32'h0000_0000, 32'd9, 32'd9,        0, 1'b1, 2, 32'd0,        1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_8000, 3'b000);
        run_txn(0, "slt_bp", 32'h0000_002A, 32'hFFFF_FFFE, 32'd1,     5, 1'b1, 3, 32'd1,        1'b0, 1'b0, 32'hFFFF_FFFE, 32'd1,        3'b111);
        run_txn(0, "ori_b2b", 32'h3400_1234, 32'h00FF_0000, 32'd0,    0, 1'b1, 3, 32'h00FF_1234, 1'b0, 1'b0, 32'h00FF_0000, 32'h1234,    3'b001);
        run_txn(0, "slti",  32'h2800_FFFF, 32'd5,        32'd0,        0, 1'b1, 3, 32'd0,        1'b1, 1'b0, 32'd5,        32'hFFFF_FFFF, 3'b111);
        run_txn(0, "illeg_op", 32'hFC00_0000, 32'd1,     32'd2,        2, 1'b1, 2, 32'd0,        1'b1, 1'b1, 32'd5,        32'hFFFF_FFFF, 3'b111);
        run_txn(0, "sw",    32'hAC00_0004, 32'h100,      32'd0,        0, 1'b1, 3, 32'h104,      1'b0, 1'b0, 32'h100,      32'd4,        3'b010);
        run_txn(0, "lw",    32'h8C00_FFFC, 32'h100,      32'd0,        0, 1'b1, 3, 32'hFC,       1'b0, 1'b0, 32'h100,      32'hFFFF_FFFC, 3'b010);
        run_txn(0, "sub",   32'h0000_0022, 32'd3,        32'd5,        0, 1'b1, 3, 32'hFFFF_FFFE, 1'b0, 1'b0, 32'd3,       32'd5,        3'b110);
        run_txn(0, "and",   32'h0000_0024, 32'h0000_F0F0, 32'h0000_FF00, 0, 1'b1, 3, 32'h0000_F000, 1'b0, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 3'b000);
        run_txn(0, "or",    32'h0000_0025, 32'h0000_F0F0, 32'h0000_FF00, 0, 1'b1, 3, 32'h0000_FFF0, 1'b0, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 3'b001);
        run_txn(1, "add_s4", 32'h00A7_3820, 32'd5,       32'd7,        0, 1'b0, 6, 32'd12,       1'b0, 1'b0, 32'd5,        32'd7,        3'b010);

        // Reset during the second EXEC cycle of the settle-4 instance.
        req_instr_s[1] = 32'h00A7_3820;
        req_rs_s[1]    = 32'd3;
        req_rt_s[1]    = 32'd4;
        req_valid_s[1] = 1'b1;
        @(posedge clk); #1;
        req_valid_s[1] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk(1, "midexec/alu_a_loaded", alu_a_w[1], 32'd3);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk(1, "midexec/req_ready", 32'(req_ready_w[1]), 32'd1);
        chk(1, "midexec/rsp_valid", 32'(rsp_valid_w[1]), 32'd0);
        chk(1, "midexec/alu_a",     alu_a_w[1], 32'd0);
        chk(1, "midexec/alu_b",     alu_b_w[1], 32'd0);
        chk(1, "midexec/alu_op",    32'(alu_op_w[1]), 32'd0);
        chk(1, "midexec/rsp_z",     rsp_z_w[1], 32'd0);
        chk(1, "midexec/rsp_err",   32'(rsp_err_w[1]), 32'd0);
        repeat (8) begin
            @(posedge clk); #1;
            chk(1, "midexec/no_rsp", 32'(rsp_valid_w[1]), 32'd0);
        end

        @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
